// File: rtl/board_sense_reader_if.sv
// board_sense_reader_if: board map handshake from the sense reader (master) to game logic (slave).
interface board_sense_reader_if;
  logic [63:0] board;
  logic        board_valid;
  logic        board_ack;
  modport master(output board, board_valid, input board_ack);
  modport slave(input board, board_valid, output board_ack);
endinterface

// File: rtl/board_sense_reader.sv
// board_sense_reader: samples the 8x8 sense matrix row by row, debounces whole frames, presents stable maps.
module board_sense_reader #(
  parameter int unsigned SETTLE_CYCLES   = 8,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [7:0]                  Row,
  input  logic [7:0]                  Col,
  board_sense_reader_if.master        bus,
  output logic                        changed,
  output logic                        frame_err,
  output logic                        overrun
);
  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
  localparam logic [7:0] SET_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] DEB      = 4'(DEBOUNCE_FRAMES);
  state_t      state_q, state_d;
  logic [7:0]  col_m_q, col_s_q, row_q, sel_q, sel_d, cnt_q, cnt_d, mask_q, mask_d;
  logic [63:0] frame_q, frame_d, cand_q, cand_d, board_q, board_d;
  logic [3:0]  stable_q, stable_d;
  logic        valid_q, valid_d, changed_q, changed_d, err_q, err_d, ovr_q, ovr_d;
  logic        abort, done, same, ready;
  always_comb begin
    abort   = !enable || !$onehot(row_q);
    err_d   = enable && !$onehot(row_q);
    done    = enable && mask_q == 8'hFF;
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    mask_d  = mask_q;
    if (abort) state_d = IDLE;
    else if (state_q == IDLE || row_q != sel_q) begin
      state_d = SETTLE;
      sel_d   = row_q;
      cnt_d   = 8'd0;
    end else if (state_q == SETTLE) begin
      if (cnt_q == SET_LAST) begin
        state_d = HELD;
        mask_d  = mask_q | sel_q;
        for (int r = 0; r < 8; r++) if (sel_q[r]) frame_d[r*8 +: 8] = col_s_q;
      end else cnt_d = cnt_q + 8'd1;
    end
    if (done || abort) mask_d = 8'h00;
    // a new candidate restarts the count at 1; a repeat saturates it at the threshold
    same      = frame_q == cand_q;
    cand_d    = done && !same ? frame_q : cand_q;
    stable_d  = !done ? stable_q : !same ? 4'd1 : stable_q < DEB ? stable_q + 4'd1 : stable_q;
    ready     = done && stable_d >= DEB && cand_d != board_q;
    changed_d = ready && !valid_q;
    board_d   = changed_d ? cand_d : board_q;
    valid_d   = changed_d || (valid_q && !bus.board_ack);
    ovr_d     = ovr_q || (ready && valid_q);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      col_m_q   <= '0;
      col_s_q   <= '0;
      row_q     <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      frame_q   <= '0;
      cand_q    <= '0;
      board_q   <= '0;
      stable_q  <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_m_q   <= Col;
      col_s_q   <= col_m_q;
      row_q     <= Row;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      frame_q   <= frame_d;
      cand_q    <= cand_d;
      board_q   <= board_d;
      stable_q  <= stable_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
    end
  end
  assign bus.board       = board_q;
  assign bus.board_valid = valid_q;
  assign changed         = changed_q;
  assign frame_err       = err_q;
  assign overrun         = ovr_q;
endmodule

// File: doc/board_sense_reader.md
# board_sense_reader

Receive side of the uChess sensor matrix. It watches the one-hot row select driven by the row scanner and samples the eight column sense lines once each row has settled. It assembles an 8x8 occupancy frame and debounces it over several consecutive frames. The stable board map is then presented to the game logic over a valid/ack handshake.

## Interface
Parameters:
- SETTLE_CYCLES, default 8: clock cycles a row must be stable before its columns are sampled; legal range 1..255.
- DEBOUNCE_FRAMES, default 3: number of consecutive identical frames required to accept a new map; legal range 1..15.

Ports:
- clock, input, 1: single system clock; all logic is on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- enable, input, 1: reader runs while high; while low the reader aborts the current frame and holds its outputs.
- Row, input, 8: one-hot row select from the scanner; bit r high means row r is driven.
- Col, input, 8: raw asynchronous column sense; bit c high means a piece is present.
- board, output, 64: accepted occupancy map; bit r*8+c is row r, column c.
- board_valid, output, 1: the `board` value is new and not yet acknowledged.
- board_ack, input, 1: the consumer takes `board`.
- changed, output, 1: one-cycle pulse when `board` is updated.
- frame_err, output, 1: one-cycle pulse when `Row` is not one-hot.
- overrun, output, 1: sticky flag; a new stable map was ready while `board_valid` was still high. Cleared by reset only.

## Operation
- Column synchronizer:
  - `Col` passes through a 2-flop synchronizer to give `col_s`.
  - `Row` is registered once to give `row_q`.
- Row FSM, states IDLE, SETTLE, HELD:
  - IDLE → SETTLE: `enable` is high and `row_q` is one-hot. The settle counter loads 0.
  - SETTLE: the counter increments each cycle while `row_q` is unchanged.
    - When the counter reaches SETTLE_CYCLES-1, capture `col_s` into frame bits [r*8+7 : r*8], set captured-mask bit r, and go to HELD.
  - HELD → SETTLE: `row_q` changes to a different one-hot value.
  - SETTLE or HELD: a change of `row_q` in SETTLE restarts the settle count for the new row; no capture is made for the old row.
  - Any state: if `row_q` is not one-hot, pulse `frame_err`, go to IDLE, and clear the captured mask.
  - Any state: if `enable` is low, go to IDLE and clear the captured mask.
  - Recapturing an already-captured row overwrites its frame byte.
- Frame complete: the captured mask reaches 0xFF, i.e. all eight rows are captured in any order. In the cycle after that, the frame is evaluated and the mask is cleared.
- Debounce, on each completed frame:
  - Frame equals candidate: stable_cnt increments, saturating at DEBOUNCE_FRAMES.
  - Otherwise: candidate loads the frame and stable_cnt becomes 1.
  - stable_cnt is 4 bits wide.
- Accept:
  - Conditions:
    - stable_cnt is at least DEBOUNCE_FRAMES after the update,
    - candidate differs from `board`,
    - `board_valid` is low.
  - Action: `board` loads candidate, `board_valid` is set, and `changed` pulses.
  - If the first two conditions hold but `board_valid` is high, `board` is not updated and `overrun` is set.
  - The deferred map is accepted at the first completed frame after ack for which the conditions still hold.
- Handshake: `board_valid` clears in the cycle after a clock edge where `board_valid` and `board_ack` are both high. `board_ack` while `board_valid` is low is ignored.
- `board` only changes on accept.

## Timing
- Reset values:
  - `board` = 0, `board_valid` = 0, `changed` = 0, `frame_err` = 0, `overrun` = 0.
  - candidate = 0, stable_cnt = 0, captured mask = 0.
  - Row FSM = IDLE.
- Column path: a `Col` edge is visible in `col_s` 2 cycles later.
- Row path: `row_q` lags `Row` by 1 cycle.
- Capture: occurs at edge 1+SETTLE_CYCLES after the edge where `Row` is first sampled with the new value.
- Accept: `changed` and `board_valid` rise 1 cycle after the capture that completes the frame.
- Ack and accept in the same cycle: ack clears the old valid first. The new accept is blocked that cycle and happens at the next frame.
- With DEBOUNCE_FRAMES=1, any differing frame is accepted immediately.
- Reset mid-frame: all state returns to reset values asynchronously; partial frames are discarded.

## Test plan
- **Clean scan:**
  - Stimulus: SETTLE=8, DEB=3; scanner cycles rows 0..7 with 20 cycles per row; Col = 0x81 on row 0 and 0 elsewhere.
  - Response: after the 3rd frame, board = 0x0000_0000_0000_0081, changed pulses once, board_valid = 1.
- **Bounce rejection:** as above, but row 3 reads 0x10 on frame 2 only. Board is accepted only after 3 equal frames following the glitch frame; board bit 28 = 0.
- **Short row:** row 5 is held for only 5 cycles with SETTLE=8. Row 5 is not captured, the frame never completes, and there is no changed pulse until a full-length row 5 is seen.
- **Bad row:**
  - Stimulus: Row = 0x0C for 1 cycle mid-frame.
  - Response: frame_err pulses 1 cycle, the mask clears, and the next accept is delayed until 3 full frames after the error.
- **Overrun:**
  - Stimulus: accept map A with no ack, then make the board stable at map B.
  - Response: board stays A and overrun = 1. After board_ack, B is accepted at the next completed frame with changed = 1.
- **Reset mid-frame:** reset asserted low during row 4. All outputs return to 0 immediately, and the next accept needs 3 complete frames.
